alu_share_arbiter: RTL and testbench

Two-port arbiter that shares one combinational 32-bit ALU (ops: add 4'b0010, sub 4'b0110, and 4'b0000, or 4'b0001, slt 4'b0111) between two requesters, e.g. the main datapath and a branch/address unit. Each port issues one operation through a valid/ready handshake. The block grants one port, drives the ALU from registered operands, captures result and zero, and returns them on that port's response handshake. It sits between the requesters and the ALU's in1/in2/control/result/zero pins.

---
 rtl/alu_share_arbiter.sv | 115 +++++++++++
 tb/tb_alu_share_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one combinational ALU through registered operands.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default is fixed priority to port 0.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             grant;
  logic             last;
  logic             pick;
  logic             accept;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  // The zero flag is derived locally so it only reflects a true sub equality.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  always_comb begin
    pick = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) pick = ~last;
    else                          pick = req1_valid;
`else
    pick = ~req0_valid;
`endif
  end

`ifndef ALU_ARB_RR_EN
  logic unused_last;
  assign unused_last = last;
`endif

  // Ready is decoded in the IDLE cycle itself so a pending request is taken with no bubble.
  assign accept     = (state == IDLE) && (req0_valid || req1_valid) && !reset;
  assign req0_ready = accept && !pick;
  assign req1_ready = accept && pick;

  assign rsp0_valid  = (state == RESP) && !grant;
  assign rsp1_valid  = (state == RESP) && grant;
  assign rsp0_result = rsp0_valid ? result_q : '0;
  assign rsp1_result = rsp1_valid ? result_q : '0;
  assign rsp0_zero   = rsp0_valid && zero_q;
  assign rsp1_zero   = rsp1_valid && zero_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last        <= 1'b1;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_control <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant       <= pick;
            alu_in1     <= pick ? req1_a  : req0_a;
            alu_in2     <= pick ? req1_b  : req0_b;
            alu_control <= pick ? req1_op : req0_op;
            state       <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          zero_q   <= (alu_control == 4'b0110) && (alu_result == '0);
          state    <= RESP;
        end
        RESP: begin
          if (grant ? rsp1_ready : rsp0_ready) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration/ALU model.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [3:0]  req0_op, req1_op, alu_control;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic        alu_zero;

  int n_assert = 0;
  int n_fail   = 0;

  // Requester-side view: pending flags, operands, response readiness.
  logic        pend[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  logic [3:0]  op[2];
  logic        rsp_rdy[2];
  int          last_m;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] c);
    case (c)
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return x ^ ~y;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_ref(alu_in1, alu_in2, alu_control);
    alu_zero   = (alu_result == 32'd0);
  end

  function automatic int model_pick();
    if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_RR_EN
      return (last_m == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return pend[1] ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    req0_valid = pend[0]; req0_a = a[0]; req0_b = b[0]; req0_op = op[0];
    req1_valid = pend[1]; req1_a = a[1]; req1_b = b[1]; req1_op = op[1];
    rsp0_ready = rsp_rdy[0];
    rsp1_ready = rsp_rdy[1];
  endtask

  task automatic chk_resp(input int p, input logic [31:0] er, input logic ez);
    chk("rsp_valid_granted", p ? rsp1_valid : rsp0_valid, 1'b1);
    chk("rsp_valid_other", p ? rsp0_valid : rsp1_valid, 1'b0);
    chk("rsp_result", p ? rsp1_result : rsp0_result, er);
    chk("rsp_zero", p ? rsp1_zero : rsp0_zero, ez);
    chk("rsp_result_other", p ? rsp0_result : rsp1_result, 32'd0);
    chk("ready_in_resp", {req0_ready, req1_ready}, 2'b00);
  endtask

  // One full operation from the current IDLE cycle; hold = cycles of rsp back-pressure.
  task automatic serve_one(input int hold);
    int p;
    logic [31:0] a_s, b_s, er;
    logic [3:0]  o_s;
    logic        ez;
    p   = model_pick();
    a_s = a[p]; b_s = b[p]; o_s = op[p];
    er  = alu_ref(a_s, b_s, o_s);
    ez  = (o_s == 4'b0110) && (er == 32'd0);
    rsp_rdy[0] = 1'b0; rsp_rdy[1] = 1'b0;
    drive(); #1;
    chk("accept_ready0", req0_ready, p == 0);
    chk("accept_ready1", req1_ready, p == 1);
    tick();
    pend[p] = 1'b0; drive(); #1;
    chk("exec_in1", alu_in1, a_s);
    chk("exec_in2", alu_in2, b_s);
    chk("exec_ctrl", alu_control, o_s);
    chk("exec_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    chk("exec_ready", {req0_ready, req1_ready}, 2'b00);
    tick();
    if (hold == 0) rsp_rdy[p] = 1'b1;
    drive(); #1;
    chk_resp(p, er, ez);
    for (int h = 0; h < hold; h++) begin
      tick();
      if (h == hold - 1) rsp_rdy[p] = 1'b1;
      drive(); #1;
      chk_resp(p, er, ez);
    end
    last_m = p;
    tick();
    rsp_rdy[p] = 1'b0; drive();
    chk("idle_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {req0_ready, req1_ready}, 2'b00);
    chk({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
    chk({tag, "_rsp_result"}, rsp0_result | rsp1_result, 32'd0);
    chk({tag, "_rsp_zero"}, {rsp0_zero, rsp1_zero}, 2'b00);
    chk({tag, "_alu_in1"}, alu_in1, 32'd0);
    chk({tag, "_alu_in2"}, alu_in2, 32'd0);
    chk({tag, "_alu_ctrl"}, alu_control, 4'b0000);
  endtask

  task automatic set_req(input int p, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] c);
    pend[p] = 1'b1; a[p] = x; b[p] = y; op[p] = c;
  endtask

  initial begin
    logic [3:0] ops [5];
    ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
    for (int q = 0; q < 2; q++) begin
      pend[q] = 1'b0; a[q] = '0; b[q] = '0; op[q] = '0; rsp_rdy[q] = 1'b0;
    end
    last_m = 1;
    reset  = 1'b1;
    pend[0] = 1'b1;
    drive();
    tick(); tick();
    chk_all_zero("reset");
    pend[0] = 1'b0; drive();
    reset = 1'b0;
    tick();

    // Single add on port 0.
    set_req(0, 32'd5, 32'd7, 4'b0010);
    serve_one(0);
    // Sub to zero then slt on port 1.
    set_req(1, 32'd9, 32'd9, 4'b0110);
    serve_one(0);
    set_req(1, 32'd3, 32'd9, 4'b0111);
    serve_one(0);

    // Both ports continuously valid.
    for (int k = 0; k < 4; k++) begin
      set_req(0, 32'd10, 32'd3, 4'b0000);
      set_req(1, 32'd12, 32'd3, 4'b0001);
      serve_one(0);
    end
    pend[0] = 1'b0; pend[1] = 1'b0; drive(); tick();

    // Back-pressure with a competing request held pending throughout.
    set_req(0, 32'd40, 32'd2, 4'b0110);
    set_req(1, 32'd1, 32'd2, 4'b0010);
    serve_one(5);
    serve_one(0);

    // Operands persist in IDLE.
    set_req(0, 32'd20, 32'd5, 4'b0110);
    serve_one(0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_in1", alu_in1, 32'd20);
      chk("hold_in2", alu_in2, 32'd5);
      chk("hold_ctrl", alu_control, 4'b0110);
    end

    // Reset during EXEC drops the operation.
    set_req(1, 32'd100, 32'd1, 4'b0010);
    drive(); #1;
    chk("pre_reset_accept", req1_ready, 1'b1);
    tick();
    pend[1] = 1'b0; drive();
    reset = 1'b1; #1;
    chk_all_zero("midop_reset");
    tick();
    reset = 1'b0; last_m = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_reset_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    end
    set_req(1, 32'd8, 32'd6, 4'b0110);
    serve_one(0);

    // Random traffic.
    for (int r = 0; r < 25; r++) begin
      for (int q = 0; q < 2; q++) begin
        int sel;
        pend[q] = 1'($urandom_range(0, 1));
        a[q] = $urandom; b[q] = $urandom;
        sel = int'($urandom_range(0, 5));
        op[q] = (sel == 5) ? 4'($urandom) : ops[sel];
        if (op[q] == 4'b0110 && $urandom_range(0, 3) == 0) b[q] = a[q];
      end
      if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
      while (pend[0] || pend[1]) serve_one(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
